// File: rtl/fe_decoder.sv
// fe_decoder: single-stage RV32I/RV64I (+ optional M) instruction decoder behind
// one valid/ready pipeline register, with a saturating illegal-word counter.
module fe_decoder #(
  parameter int XLEN  = 32,
  parameter int EN_M  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_mnemonic,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("fe_decoder: XLEN must be 32 or 64");
  end

  localparam logic [5:0] MN_NULL  = 6'd63;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  fmt_t            fmt;
  logic [5:0]      dec_mn;
  logic            dec_illegal;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0] dec_imm;
  logic            shift_l_ok, shift_a_ok;
  logic [31:0]     imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  logic            accept;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'({{32{v[31]}}, v});
  endfunction

  assign imm_i32 = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign imm_u32 = {in_instr[31:12], 12'b0};
  assign imm_j32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  // RV64 widens shamt to six bits, leaving only instr[31:26] as the funct field
  if (XLEN == 64) begin : g_sh64
    assign shift_l_ok = in_instr[31:26] == 6'b000000;
    assign shift_a_ok = in_instr[31:26] == 6'b010000;
  end else begin : g_sh32
    assign shift_l_ok = funct7 == 7'b0000000;
    assign shift_a_ok = funct7 == 7'b0100000;
  end

  always_comb begin
    fmt    = FMT_NONE;
    dec_mn = MN_NULL;
    case (opcode)
      OP_R: begin
        fmt = FMT_R;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_mn = 6'd0;
            3'b001:  dec_mn = 6'd5;
            3'b010:  dec_mn = 6'd8;
            3'b011:  dec_mn = 6'd9;
            3'b100:  dec_mn = 6'd2;
            3'b101:  dec_mn = 6'd6;
            3'b110:  dec_mn = 6'd3;
            default: dec_mn = 6'd4;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) dec_mn = 6'd1;
          else if (funct3 == 3'b101) dec_mn = 6'd7;
        end else if (funct7 == 7'b0000001 && EN_M != 0) begin
          dec_mn = 6'd39 + {3'b000, funct3};
        end
      end
      OP_I: begin
        fmt = FMT_I;
        case (funct3)
          3'b000:  dec_mn = 6'd10;
          3'b100:  dec_mn = 6'd11;
          3'b110:  dec_mn = 6'd12;
          3'b111:  dec_mn = 6'd13;
          3'b010:  dec_mn = 6'd17;
          3'b011:  dec_mn = 6'd18;
          3'b001:  if (shift_l_ok) dec_mn = 6'd14;
          default: begin
            if (shift_l_ok) dec_mn = 6'd15;
            else if (shift_a_ok) dec_mn = 6'd16;
          end
        endcase
      end
      OP_LOAD: begin
        fmt = FMT_I;
        case (funct3)
          3'b000:  dec_mn = 6'd19;
          3'b001:  dec_mn = 6'd20;
          3'b010:  dec_mn = 6'd21;
          3'b100:  dec_mn = 6'd22;
          3'b101:  dec_mn = 6'd23;
          default: dec_mn = MN_NULL;
        endcase
      end
      OP_JALR: begin
        fmt = FMT_I;
        if (funct3 == 3'b000) dec_mn = 6'd24;
      end
      OP_SYS: begin
        fmt = FMT_I;
        if (in_instr == 32'h0000_0073) dec_mn = 6'd25;
        else if (in_instr == 32'h0010_0073) dec_mn = 6'd26;
      end
      OP_S: begin
        fmt = FMT_S;
        case (funct3)
          3'b000:  dec_mn = 6'd27;
          3'b001:  dec_mn = 6'd28;
          3'b010:  dec_mn = 6'd29;
          default: dec_mn = MN_NULL;
        endcase
      end
      OP_B: begin
        fmt = FMT_B;
        case (funct3)
          3'b000:  dec_mn = 6'd30;
          3'b001:  dec_mn = 6'd31;
          3'b100:  dec_mn = 6'd32;
          3'b101:  dec_mn = 6'd33;
          3'b110:  dec_mn = 6'd34;
          3'b111:  dec_mn = 6'd35;
          default: dec_mn = MN_NULL;
        endcase
      end
      OP_JAL: begin
        fmt    = FMT_J;
        dec_mn = 6'd36;
      end
      OP_LUI: begin
        fmt    = FMT_U;
        dec_mn = 6'd37;
      end
      OP_AUIPC: begin
        fmt    = FMT_U;
        dec_mn = 6'd38;
      end
      default: fmt = FMT_NONE;
    endcase
  end

  assign dec_illegal = dec_mn == MN_NULL;

  // Illegal words expose all raw register fields; the immediate still follows the opcode's format
  always_comb begin
    dec_rd  = 5'd0;
    dec_rs1 = 5'd0;
    dec_rs2 = 5'd0;
    dec_imm = '0;
    if (dec_illegal) begin
      dec_rd  = in_instr[11:7];
      dec_rs1 = in_instr[19:15];
      dec_rs2 = in_instr[24:20];
    end else begin
      case (fmt)
        FMT_R: begin
          dec_rd  = in_instr[11:7];
          dec_rs1 = in_instr[19:15];
          dec_rs2 = in_instr[24:20];
        end
        FMT_I: begin
          dec_rd  = in_instr[11:7];
          dec_rs1 = in_instr[19:15];
        end
        FMT_S, FMT_B: begin
          dec_rs1 = in_instr[19:15];
          dec_rs2 = in_instr[24:20];
        end
        FMT_U, FMT_J: dec_rd = in_instr[11:7];
        default: dec_rd = 5'd0;
      endcase
    end
    case (fmt)
      FMT_I:   dec_imm = sext32(imm_i32);
      FMT_S:   dec_imm = sext32(imm_s32);
      FMT_B:   dec_imm = sext32(imm_b32);
      FMT_U:   dec_imm = sext32(imm_u32);
      FMT_J:   dec_imm = sext32(imm_j32);
      default: dec_imm = '0;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Reset beats flush, flush beats accept; a flushed word is neither held nor counted
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_illegal   <= 1'b0;
      out_mnemonic  <= MN_NULL;
      out_rd        <= 5'd0;
      out_rs1       <= 5'd0;
      out_rs2       <= 5'd0;
      out_imm       <= '0;
      out_pc        <= '0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_illegal  <= dec_illegal;
      out_mnemonic <= dec_mn;
      out_rd       <= dec_rd;
      out_rs1      <= dec_rs1;
      out_rs2      <= dec_rs2;
      out_imm      <= dec_imm;
      out_pc       <= in_pc;
      if (dec_illegal && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fe_decoder.sv
// tb_fe_decoder: drives an RV32 (no M) and an RV64 (with M, 4-bit counter) decoder
// with shared stimulus and compares both against a mask/match reference model.
module tb_fe_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [63:0] in_pc = 64'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [5:0]  a_out_mnemonic;
  logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
  logic [31:0] a_out_imm, a_out_pc;
  logic [15:0] a_illegal_count;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [5:0]  b_out_mnemonic;
  logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
  logic [63:0] b_out_imm, b_out_pc;
  logic [3:0]  b_illegal_count;

  always #5 clk = ~clk;

  fe_decoder #(.XLEN(32), .EN_M(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_mnemonic(a_out_mnemonic),
    .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
    .out_imm(a_out_imm), .out_pc(a_out_pc), .out_illegal(a_out_illegal),
    .illegal_count(a_illegal_count)
  );

  fe_decoder #(.XLEN(64), .EN_M(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_mnemonic(b_out_mnemonic),
    .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_imm(b_out_imm), .out_pc(b_out_pc), .out_illegal(b_out_illegal),
    .illegal_count(b_illegal_count)
  );

  wire [102:0] obs_a = {a_out_valid, a_out_illegal, a_out_mnemonic, a_out_rd, a_out_rs1,
                        a_out_rs2, a_out_imm, a_out_pc, a_illegal_count};
  wire [154:0] obs_b = {b_out_valid, b_out_illegal, b_out_mnemonic, b_out_rd, b_out_rs1,
                        b_out_rs2, b_out_imm, b_out_pc, b_illegal_count};

  typedef struct packed {
    bit        valid;
    bit        ill;
    bit [5:0]  mn;
    bit [4:0]  rd, rs1, rs2;
    bit [63:0] imm, pc;
    int        cnt;
  } mstate_t;

  mstate_t     ma, mb;
  logic [31:0] t_match [47];
  logic [31:0] t_mask  [47];
  logic [1:0]  rdy_obs, rdy_exp;
  int          n_checks = 0;
  int          n_pass = 0;

  // Standard RISC-V match/mask pairs, indexed by mnemonic code
  task automatic init_table();
    logic [31:0] r_f3 [10];
    logic [31:0] i_f3 [9];
    r_f3 = '{32'h0000_0033, 32'h4000_0033, 32'h0000_4033, 32'h0000_6033, 32'h0000_7033,
             32'h0000_1033, 32'h0000_5033, 32'h4000_5033, 32'h0000_2033, 32'h0000_3033};
    i_f3 = '{32'h0000_0013, 32'h0000_4013, 32'h0000_6013, 32'h0000_7013, 32'h0000_1013,
             32'h0000_5013, 32'h4000_5013, 32'h0000_2013, 32'h0000_3013};
    for (int c = 0; c < 10; c++) begin t_match[c] = r_f3[c]; t_mask[c] = 32'hFE00_707F; end
    for (int c = 0; c < 9; c++) begin
      t_match[10+c] = i_f3[c];
      t_mask[10+c]  = (c >= 4 && c <= 6) ? 32'hFE00_707F : 32'h0000_707F;
    end
    t_match[19] = 32'h0000_0003; t_match[20] = 32'h0000_1003; t_match[21] = 32'h0000_2003;
    t_match[22] = 32'h0000_4003; t_match[23] = 32'h0000_5003; t_match[24] = 32'h0000_0067;
    for (int c = 19; c <= 24; c++) t_mask[c] = 32'h0000_707F;
    t_match[25] = 32'h0000_0073; t_mask[25] = 32'hFFFF_FFFF;
    t_match[26] = 32'h0010_0073; t_mask[26] = 32'hFFFF_FFFF;
    t_match[27] = 32'h0000_0023; t_match[28] = 32'h0000_1023; t_match[29] = 32'h0000_2023;
    t_match[30] = 32'h0000_0063; t_match[31] = 32'h0000_1063; t_match[32] = 32'h0000_4063;
    t_match[33] = 32'h0000_5063; t_match[34] = 32'h0000_6063; t_match[35] = 32'h0000_7063;
    for (int c = 27; c <= 35; c++) t_mask[c] = 32'h0000_707F;
    t_match[36] = 32'h0000_006F; t_match[37] = 32'h0000_0037; t_match[38] = 32'h0000_0017;
    for (int c = 36; c <= 38; c++) t_mask[c] = 32'h0000_007F;
    for (int c = 0; c < 8; c++) begin
      t_match[39+c] = 32'h0200_0033 | (32'(c) << 12);
      t_mask[39+c]  = 32'hFE00_707F;
    end
  endtask

  function automatic mstate_t reset_state();
    mstate_t s;
    s = '0;
    s.mn = 6'd63;
    return s;
  endfunction

  function automatic mstate_t ref_decode(logic [31:0] w, logic [63:0] pc, bit x64, bit m);
    mstate_t     d;
    logic [31:0] mk;
    longint      li;
    byte         fmt;
    int          code;
    code = 63;
    for (int c = 0; c < 47; c++) begin
      mk = t_mask[c];
      if (x64 && c >= 14 && c <= 16) mk = 32'hFC00_707F;
      if ((m || c < 39) && ((w & mk) == t_match[c])) code = c;
    end
    case (w[6:0])
      7'b0110011:                         fmt = "R";
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011:                         fmt = "I";
      7'b0100011:                         fmt = "S";
      7'b1100011:                         fmt = "B";
      7'b1101111:                         fmt = "J";
      7'b0110111, 7'b0010111:             fmt = "U";
      default:                            fmt = "-";
    endcase
    d       = '0;
    d.valid = 1'b1;
    d.mn    = 6'(code);
    d.ill   = (code == 63);
    d.pc    = pc;
    if (d.ill || fmt == "R" || fmt == "I" || fmt == "U" || fmt == "J") d.rd = w[11:7];
    if (d.ill || fmt == "R" || fmt == "I" || fmt == "S" || fmt == "B") d.rs1 = w[19:15];
    if (d.ill || fmt == "R" || fmt == "S" || fmt == "B") d.rs2 = w[24:20];
    li = $signed(w);
    case (fmt)
      "I": d.imm = li >>> 20;
      "S": d.imm = ((li >>> 25) <<< 5) | longint'((w >> 7) & 32'h1F);
      "B": d.imm = ((li >>> 31) <<< 12) | longint'(((w >> 7) & 32'h1) << 11) |
                   longint'(((w >> 25) & 32'h3F) << 5) | longint'(((w >> 8) & 32'hF) << 1);
      "U": d.imm = (li >>> 12) <<< 12;
      "J": d.imm = ((li >>> 31) <<< 20) | longint'(w & 32'h000F_F000) |
                   longint'(((w >> 20) & 32'h1) << 11) | longint'(((w >> 21) & 32'h3FF) << 1);
      default: d.imm = 64'd0;
    endcase
    return d;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit x64, bit m, int cmax);
    mstate_t n;
    n = s;
    if (rst) n = reset_state();
    else if (flush) n.valid = 1'b0;
    else if (in_valid && (!s.valid || out_ready)) begin
      n = ref_decode(in_instr, in_pc, x64, m);
      n.cnt = s.cnt + ((n.ill && s.cnt < cmax) ? 1 : 0);
    end else if (out_ready) n.valid = 1'b0;
    return n;
  endfunction

  function automatic logic [102:0] pack_a(mstate_t s);
    return {s.valid, s.ill, s.mn, s.rd, s.rs1, s.rs2, s.imm[31:0], s.pc[31:0], s.cnt[15:0]};
  endfunction

  function automatic logic [154:0] pack_b(mstate_t s);
    return {s.valid, s.ill, s.mn, s.rd, s.rs1, s.rs2, s.imm, s.pc, s.cnt[3:0]};
  endfunction

  function automatic logic [31:0] rand_legal();
    int c;
    c = $urandom_range(0, 46);
    return t_match[c] | ($urandom & ~t_mask[c]);
  endfunction

  // One clock: apply inputs, sample in_ready before the edge, advance the model, settle
  task automatic apply_stimulus(bit v, logic [31:0] w, bit f, bit r, bit rs);
    in_valid  = v;
    in_instr  = w;
    in_pc     = {$urandom, $urandom};
    flush     = f;
    out_ready = r;
    rst       = rs;
    #1;
    rdy_obs = {a_in_ready, b_in_ready};
    rdy_exp = {!ma.valid || r, !mb.valid || r};
    ma = model_next(ma, 1'b0, 1'b0, 65535);
    mb = model_next(mb, 1'b1, 1'b1, 15);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_stimulus(0, 32'd0, 0, 0, 1);
    apply_stimulus(0, 32'd0, 0, 0, 1);
    n_checks++;
    if (obs_a !== {2'b00, 6'd63, 95'd0}) $display("[TB] FAIL reset_a: got %h want %h", obs_a, {2'b00, 6'd63, 95'd0});
    else n_pass++;
    n_checks++;
    if (obs_b !== {2'b00, 6'd63, 147'd0}) $display("[TB] FAIL reset_b: got %h want %h", obs_b, {2'b00, 6'd63, 147'd0});
    else n_pass++;
  endtask

  task automatic test_directed();
    apply_stimulus(1, 32'h0020_81B3, 0, 1, 0);
    n_checks++;
    if ({a_out_valid, a_out_mnemonic, a_out_rd, a_out_rs1, a_out_rs2, a_out_imm} !==
        {1'b1, 6'd0, 5'd3, 5'd1, 5'd2, 32'd0})
      $display("[TB] FAIL add_fields: got %b %0d %0d %0d %0d %h want 1 0 3 1 2 0",
               a_out_valid, a_out_mnemonic, a_out_rd, a_out_rs1, a_out_rs2, a_out_imm);
    else n_pass++;
    n_checks++;
    if (obs_b !== pack_b(mb)) $display("[TB] FAIL add_model_b: got %h want %h", obs_b, pack_b(mb));
    else n_pass++;
    apply_stimulus(1, 32'hFFF0_0093, 0, 1, 0);
    n_checks++;
    if ({a_out_mnemonic, a_out_rd, a_out_imm, b_out_imm} !== {6'd10, 5'd1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF})
      $display("[TB] FAIL addi_neg1: got %0d %0d %h %h want 10 1 ffffffff ffffffffffffffff",
               a_out_mnemonic, a_out_rd, a_out_imm, b_out_imm);
    else n_pass++;
    apply_stimulus(1, 32'hFE00_0EE3, 0, 1, 0);
    n_checks++;
    if ({a_out_mnemonic, b_out_mnemonic, a_out_imm, b_out_imm} !== {6'd30, 6'd30, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC})
      $display("[TB] FAIL beq_back: got %0d %0d %h %h want 30 30 -4",
               a_out_mnemonic, b_out_mnemonic, a_out_imm, b_out_imm);
    else n_pass++;
    n_checks++;
    if (obs_a !== pack_a(ma)) $display("[TB] FAIL beq_model_a: got %h want %h", obs_a, pack_a(ma));
    else n_pass++;
    apply_stimulus(0, 32'd0, 0, 1, 0);
  endtask

  task automatic test_m_ext();
    apply_stimulus(0, 32'd0, 0, 1, 1);
    apply_stimulus(1, 32'h0231_00B3, 0, 1, 0);
    n_checks++;
    if ({a_out_mnemonic, a_out_illegal, a_illegal_count} !== {6'd63, 1'b1, 16'd1})
      $display("[TB] FAIL mul_no_m: got %0d %b %0d want 63 1 1", a_out_mnemonic, a_out_illegal, a_illegal_count);
    else n_pass++;
    n_checks++;
    if ({b_out_mnemonic, b_out_illegal, b_illegal_count} !== {6'd39, 1'b0, 4'd0})
      $display("[TB] FAIL mul_with_m: got %0d %b %0d want 39 0 0", b_out_mnemonic, b_out_illegal, b_illegal_count);
    else n_pass++;
    apply_stimulus(0, 32'd0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    logic [102:0] snap_a;
    logic [154:0] snap_b;
    apply_stimulus(1, rand_legal(), 0, 0, 0);
    snap_a = pack_a(ma);
    snap_b = pack_b(mb);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, rand_legal(), 0, 0, 0);
      n_checks++;
      if (rdy_obs !== 2'b00 || obs_a !== snap_a || obs_b !== snap_b)
        $display("[TB] FAIL stall_hold[%0d]: ready %b a %h b %h want ready 00 a %h b %h",
                 i, rdy_obs, obs_a, obs_b, snap_a, snap_b);
      else n_pass++;
    end
    apply_stimulus(1, 32'h0000_0037 | (32'h12345 << 12), 0, 1, 0);
    n_checks++;
    if (rdy_obs !== 2'b11 || a_out_mnemonic !== 6'd37 || obs_a !== pack_a(ma) || obs_b !== pack_b(mb))
      $display("[TB] FAIL stall_release: ready %b mn %0d a %h want ready 11 mn 37 a %h",
               rdy_obs, a_out_mnemonic, obs_a, pack_a(ma));
    else n_pass++;
    apply_stimulus(0, 32'd0, 0, 1, 0);
  endtask

  task automatic test_flush();
    int cnt_before;
    cnt_before = ma.cnt;
    apply_stimulus(1, 32'h0000_0000, 1, 1, 0);
    n_checks++;
    if (a_out_valid !== 1'b0 || a_illegal_count !== 16'(cnt_before) || obs_b !== pack_b(mb))
      $display("[TB] FAIL flush_drop: valid %b count %0d want valid 0 count %0d",
               a_out_valid, a_illegal_count, cnt_before);
    else n_pass++;
    apply_stimulus(1, rand_legal(), 0, 0, 0);
    apply_stimulus(0, 32'd0, 1, 0, 0);
    n_checks++;
    if ({a_out_valid, b_out_valid} !== 2'b00 || obs_a !== pack_a(ma))
      $display("[TB] FAIL flush_held: valid %b%b a %h want 00 a %h", a_out_valid, b_out_valid, obs_a, pack_a(ma));
    else n_pass++;
  endtask

  task automatic test_saturation();
    apply_stimulus(0, 32'd0, 0, 1, 1);
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(1, 32'h0000_0000, 0, 1, 0);
      n_checks++;
      if (obs_a !== pack_a(ma) || obs_b !== pack_b(mb))
        $display("[TB] FAIL sat_step[%0d]: a %h b %h want a %h b %h", i, obs_a, obs_b, pack_a(ma), pack_b(mb));
      else n_pass++;
    end
    n_checks++;
    if (b_illegal_count !== 4'hF || a_illegal_count !== 16'd18)
      $display("[TB] FAIL sat_final: b %0d a %0d want b 15 a 18", b_illegal_count, a_illegal_count);
    else n_pass++;
  endtask

  task automatic test_rst_stalled();
    apply_stimulus(1, rand_legal(), 0, 0, 0);
    apply_stimulus(1, rand_legal(), 1, 0, 1);
    n_checks++;
    if (obs_a !== {2'b00, 6'd63, 95'd0} || obs_b !== {2'b00, 6'd63, 147'd0})
      $display("[TB] FAIL rst_stalled: a %h b %h want reset values", obs_a, obs_b);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom % 2 == 0) ? rand_legal() : $urandom;
      apply_stimulus($urandom % 4 != 0, w, $urandom % 16 == 0, $urandom % 3 != 0, $urandom % 64 == 0);
      n_checks++;
      if (rdy_obs !== rdy_exp) $display("[TB] FAIL rand_ready[%0d]: got %b want %b", i, rdy_obs, rdy_exp);
      else n_pass++;
      n_checks++;
      if (obs_a !== pack_a(ma)) $display("[TB] FAIL rand_a[%0d] w=%h: got %h want %h", i, w, obs_a, pack_a(ma));
      else n_pass++;
      n_checks++;
      if (obs_b !== pack_b(mb)) $display("[TB] FAIL rand_b[%0d] w=%h: got %h want %h", i, w, obs_b, pack_b(mb));
      else n_pass++;
    end
  endtask

  initial begin
    init_table();
    ma = reset_state();
    mb = reset_state();
    test_reset();
    test_directed();
    test_m_ext();
    test_backpressure();
    test_flush();
    test_saturation();
    test_rst_stalled();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fe_decoder.md
FE_DECODER -- requirements
Module: fe_decoder

Interface
REQ-001 XLEN, 32, datapath width; SHALL be 32 or 64, any other value a elaboration error.
REQ-002 EN_M, 0, 1 enables M-extension decode; 0 flags M encodings illegal.
REQ-003 CNT_W, 16, width of illegal-instruction counter.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  fetch word offered.
REQ-007 in_ready  out  1  decoder accepts word this cycle.
REQ-008 in_instr  in  32  raw instruction.
REQ-009 in_pc  in  XLEN  PC of in_instr.
REQ-010 flush  in  1  discard held and incoming word.
REQ-011 out_valid  out  1  decoded word held.
REQ-012 out_ready  in  1  downstream accepts held word.
REQ-013 out_mnemonic  out  6  mnemonic code per REQ-020.
REQ-014 out_rd / out_rs1 / out_rs2  out  5 each  register fields; 0 when the format lacks the field.
REQ-015 out_imm  out  XLEN  sign-extended immediate; 0 for R-type.
REQ-016 out_pc  out  XLEN  registered in_pc.
REQ-017 out_illegal  out  1  held word is illegal.
REQ-018 illegal_count  out  CNT_W  saturating count of accepted illegal words.

Function
REQ-019 One pipeline register; accept = in_valid & in_ready; in_ready = !out_valid | out_ready (combinational, no skid buffer); decode latency exactly 1 cycle.
REQ-020 Codes: ADD..SLTU 0-9, ADDI..EBREAK 10-26 (order ADDI XORI ORI ANDI SLLI SRLI SRAI SLTI SLTIU LB LH LW LBU LHU JALR ECALL EBREAK), SB SH SW 27-29, BEQ..BGEU 30-35, JAL 36, LUI 37, AUIPC 38, MUL MULH MULHSU MULHU DIV DIVU REM REMU 39-46, NULL 63.
REQ-021 Opcodes: R 0110011, I 0010011, LOAD 0000011, JALR 1100111, SYS 1110011, S 0100011, B 1100011, JAL 1101111, LUI 0110111, AUIPC 0010111; any other opcode -> NULL, illegal.
REQ-022 instr[1:0] != 2'b11 -> NULL, illegal.
REQ-023 R-type: funct7 0000000 or 0100000 (SUB, SRA only) legal; 0000001 legal only if EN_M=1; else illegal.
REQ-024 Shift-imm: XLEN=32 shamt instr[24:20], instr[31:25] must be 0000000 (SLLI/SRLI) or 0100000 (SRAI); XLEN=64 shamt instr[25:20], instr[31:26] 000000/010000; violation illegal.
REQ-025 ECALL only for exact 0x00000073, EBREAK only 0x00100073; other SYS words illegal.
REQ-026 Illegal funct3 for LOAD (011,110,111), S (>=011), B (010,011), JALR (!=000) -> illegal.
REQ-027 Immediates per I/S/B/U/J formats, B and J with bit0=0, U = instr[31:12]<<12, all sign-extended from their MSB to XLEN.
REQ-028 Illegal words still pass through with out_illegal=1, mnemonic NULL, fields decoded as raw bit positions.
REQ-029 Held word stable while out_valid & !out_ready.
REQ-030 flush: next cycle out_valid=0; a word accepted in the flush cycle is dropped and not counted.
REQ-031 illegal_count increments by 1 on accept of an illegal word without flush; saturates at all-ones.

Reset
REQ-032 rst in any cycle: next cycle out_valid=0, out_illegal=0, out_mnemonic=63, rd/rs1/rs2/imm/pc=0, illegal_count=0; rst overrides accept and flush.

Verification
REQ-033 0x002081B3 accepted, out_ready=1 -> next cycle out_valid=1, mnemonic 0, rd=3, rs1=1, rs2=2, imm=0.
REQ-034 0xFFF00093 -> mnemonic 10, rd=1, imm all-ones (XLEN=32 and 64); 0xFE000EE3 -> mnemonic 30, imm=-4.
REQ-035 out_ready=0 with out_valid=1 for 5 cycles -> in_ready=0, outputs unchanged; out_ready=1 -> next word loads following cycle.
REQ-036 0x023100B3 with EN_M=0 -> mnemonic 63, illegal=1, count=1; EN_M=1 -> mnemonic 39, illegal=0, count=0.
REQ-037 Illegal word accepted with flush=1 -> out_valid=0, count unchanged; count preset near max by 2^CNT_W+2 illegal words -> holds all-ones.
REQ-038 rst asserted while out_valid=1, out_ready=0 -> next cycle all outputs at REQ-032 values.
